fadd_align: RTL

- Two-stage pipelined operand pre-alignment stage that sits directly upstream of the single-precision combinational adder core.
- Accepts two IEEE-754 binary32 operands over a valid/ready handshake.
- Classifies special operands, orders the operands by magnitude, and right-shifts the smaller significand by the exponent difference, keeping guard/round/sticky bits.
- Emits aligned significands to the add/normalise stage with its own valid/ready handshake.

---
 rtl/fadd_align.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fadd_align.sv
// Operand pre-alignment for the binary32 adder: classify specials, order by magnitude,
// then shift the smaller significand right by the exponent difference with sticky.
module fadd_align #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [EXP_W-1:0]         out_exp,
  output logic [MAN_W+3:0]         out_mant_l,
  output logic [MAN_W+3:0]         out_mant_s,
  output logic                     out_sub,
  output logic                     out_special,
  output logic [EXP_W+MAN_W:0]     out_special_res
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int AW = MAN_W + 4;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: a stage accepts when it is empty or its contents move on this edge.
  // A transfer happens on a rising edge where valid and ready are both high; in_ready
  // is derived from register state and out_ready only, never from in_valid.
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;
  logic rdy_q;
  logic in_fire;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = rdy_q && s1_adv;
  assign in_fire  = in_valid && in_ready;

  logic             sign_a;
  logic             sign_b;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] frac_a;
  logic [MAN_W-1:0] frac_b;

  assign {sign_a, exp_a, frac_a} = a;
  assign {sign_b, exp_b, frac_b} = b;

  // Denormals carry exp==0 and are treated as signed zero.
  logic zero_a;
  logic zero_b;
  logic inf_a;
  logic inf_b;
  logic nan_a;
  logic nan_b;

  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == '1) && (frac_a == '0);
  assign inf_b  = (exp_b == '1) && (frac_b == '0);
  assign nan_a  = (exp_a == '1) && (frac_a != '0);
  assign nan_b  = (exp_b == '1) && (frac_b != '0);

  logic         spec;
  logic [W-1:0] spec_res;

  always_comb begin
    spec     = 1'b1;
    spec_res = '0;
    if (nan_a || nan_b) begin
      spec_res = QNAN;
    end else if (inf_a && inf_b && (sign_a != sign_b)) begin
      spec_res = QNAN;
    end else if (inf_a) begin
      spec_res = a;
    end else if (inf_b) begin
      spec_res = b;
    end else if (zero_a && zero_b) begin
      spec_res = {sign_a & sign_b, {(W-1){1'b0}}};
    end else if (zero_a) begin
      spec_res = b;
    end else if (zero_b) begin
      spec_res = a;
    end else begin
      spec = 1'b0;
    end
  end

  // Magnitude order on {exp, frac}; a tie keeps A as the larger operand.
  logic             a_is_l;
  logic             sign_l;
  logic [EXP_W-1:0] exp_l;
  logic [EXP_W-1:0] exp_s;
  logic [MAN_W-1:0] frac_l;
  logic [MAN_W-1:0] frac_s;
  logic [EXP_W-1:0] diff;

  assign a_is_l = ({exp_a, frac_a} >= {exp_b, frac_b});
  assign sign_l = a_is_l ? sign_a : sign_b;
  assign exp_l  = a_is_l ? exp_a  : exp_b;
  assign exp_s  = a_is_l ? exp_b  : exp_a;
  assign frac_l = a_is_l ? frac_a : frac_b;
  assign frac_s = a_is_l ? frac_b : frac_a;
  assign diff   = exp_l - exp_s;

  logic             s1_special;
  logic [W-1:0]     s1_special_res;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W-1:0] s1_frac_l;
  logic [MAN_W-1:0] s1_frac_s;
  logic [EXP_W-1:0] s1_diff;
  logic             s1_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q          <= 1'b0;
      s1_valid       <= 1'b0;
      s1_special     <= 1'b0;
      s1_special_res <= '0;
      s1_sign        <= 1'b0;
      s1_exp         <= '0;
      s1_frac_l      <= '0;
      s1_frac_s      <= '0;
      s1_diff        <= '0;
      s1_sub         <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (s1_adv) begin
        s1_valid <= in_fire;
      end
      if (in_fire) begin
        s1_special     <= spec;
        s1_special_res <= spec_res;
        s1_sign        <= sign_l;
        s1_exp         <= exp_l;
        s1_frac_l      <= frac_l;
        s1_frac_s      <= frac_s;
        s1_diff        <= diff;
        s1_sub         <= sign_a ^ sign_b;
      end
    end
  end

  // The low half of the double-width shift holds every bit pushed past the LSB.
  logic [AW-1:0]   m_s;
  logic [2*AW-1:0] wide;
  logic [AW-1:0]   aligned;

  assign m_s  = {1'b1, s1_frac_s, 3'b000};
  assign wide = {m_s, {AW{1'b0}}} >> s1_diff;

  always_comb begin
    if (int'(s1_diff) >= AW) begin
      aligned = AW'(1);
    end else begin
      aligned = {wide[2*AW-1:AW+1], wide[AW] | (|wide[AW-1:0])};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_sign        <= 1'b0;
      out_exp         <= '0;
      out_mant_l      <= '0;
      out_mant_s      <= '0;
      out_sub         <= 1'b0;
      out_special     <= 1'b0;
      out_special_res <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign        <= s1_sign;
        out_exp         <= s1_exp;
        out_mant_l      <= {1'b1, s1_frac_l, 3'b000};
        out_mant_s      <= aligned;
        out_sub         <= s1_sub;
        out_special     <= s1_special;
        out_special_res <= s1_special_res;
      end
    end
  end

endmodule
